// File: rtl/fas_pkg.sv
// fas_pkg: shared definitions for the serial full adder/subtractor.
//   state_e     - control FSM states (IDLE, RUN)
//   num_digits  - K = WIDTH/DIGIT, the number of RUN cycles per operation
//   cnt_width   - width of a counter that can hold 0..K
package fas_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int unsigned num_digits(input int unsigned width,
                                               input int unsigned digit);
        return width / digit;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned width,
                                              input int unsigned digit);
        return $clog2(num_digits(width, digit) + 1);
    endfunction

endpackage

// File: rtl/fas.sv
// fas: single-bit full adder/subtractor cell.
//   a, b  - operand bits
//   cin   - carry in
//   a_ns  - 1 = add, 0 = subtract (b is inverted inside the cell)
//   s     - sum bit
//   cout  - carry out
module fas (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic a_ns,
    output logic s,
    output logic cout
);

    logic b_eff;

    assign b_eff = b ^ ~a_ns;
    assign s     = a ^ b_eff ^ cin;
    assign cout  = (a & b_eff) | (cin & (a ^ b_eff));

endmodule

// File: rtl/fas_digit.sv
// fas_digit: combinational DIGIT-bit ripple slice built from fas cells.
//   a, b   - DIGIT-bit operand slices (b arrives already inverted for subtract)
//   cin    - carry into bit 0
//   sum    - DIGIT-bit result slice
//   cout   - carry out of bit DIGIT-1
//   c_msb  - carry into bit DIGIT-1, used for signed overflow on the last slice
module fas_digit #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        // The slice always adds: subtract mode is folded into b at accept.
        fas u_fas (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .a_ns (1'b1),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/fas_serial.sv
// fas_serial: digit-serial WIDTH-bit adder/subtractor, DIGIT bits per clock,
// LSB first, K = WIDTH/DIGIT cycles per operation.
//   clk, rst        - clock, synchronous active-high reset
//   start           - operation request
//   a, b, cin, a_ns - operands, carry-in and mode (1 = add, 0 = subtract)
//   ready           - a start on this edge will be accepted
//   done            - one-cycle pulse, s/cout/ovf valid
//   s, cout, ovf    - result, carry out of MSB, signed overflow
//   state_dbg       - current FSM state
//
// Handshake: an operation is accepted on a rising edge where start=1 and
// ready=1; a, b, cin and a_ns are captured on that edge only. ready is low
// for the K RUN cycles that follow, during which start is ignored (no
// queueing). done pulses for the single cycle after the last RUN edge, and
// ready is already high in that cycle so a new start can be accepted
// back-to-back. s, cout and ovf change only on the done edge and hold until
// the next done or reset.
module fas_serial
    import fas_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             a_ns,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output state_e           state_dbg
);

    if (WIDTH < 2) begin : g_bad_width
        $error("fas_serial: WIDTH must be at least 2");
    end
    if (DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("fas_serial: DIGIT must divide WIDTH");
    end

    localparam int unsigned K  = num_digits(WIDTH, DIGIT);
    localparam int unsigned CW = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout;
    logic             dig_cmsb;
    logic [WIDTH-1:0] acc_shift;

    fas_digit #(.DIGIT(DIGIT)) u_digit (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .cin   (carry_q),
        .sum   (dig_sum),
        .cout  (dig_cout),
        .c_msb (dig_cmsb)
    );

    // New digits enter from the MSB side so that after K shifts the first
    // (least significant) digit has reached bit 0.
    if (DIGIT == WIDTH) begin : g_one_digit
        assign acc_shift = dig_sum;
    end else begin : g_multi_digit
        assign acc_shift = {dig_sum, acc_q[WIDTH-1:DIGIT]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = a_ns ? b : ~b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dig_cout;
                acc_d   = acc_shift;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    s_d     = acc_shift;
                    cout_d  = dig_cout;
                    // Signed overflow: carry into the MSB differs from carry out.
                    ovf_d   = dig_cout ^ dig_cmsb;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign done      = done_q;
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fas_serial.sv
// tb_fas_serial: bench for fas_serial. Six instances: WIDTH=8 with DIGIT 1
// and 2 for the directed vectors, WIDTH=16 with DIGIT 1, 2, 4, 8 for the
// random regression. A cycle-level model of each instance predicts every
// output on every cycle from plain arithmetic on the accepted operands.
module tb_fas_serial;

    localparam int NI = 6;

    function automatic int w_of(input int i);
        return (i < 2) ? 8 : 16;
    endfunction

    function automatic int d_of(input int i);
        return (i < 2) ? (i + 1) : (1 << (i - 2));
    endfunction

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start   [NI];
    logic [15:0]   a_in    [NI];
    logic [15:0]   b_in    [NI];
    logic          cin_in  [NI];
    logic          ans_in  [NI];
    logic          ready_o [NI];
    logic          done_o  [NI];
    logic [15:0]   s_o     [NI];
    logic          cout_o  [NI];
    logic          ovf_o   [NI];
    fas_pkg::state_e st_o  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        if (g < 2) begin : g_w8
            logic [7:0] s8;
            fas_serial #(.WIDTH(8), .DIGIT(g + 1)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .start     (start[g]),
                .a         (a_in[g][7:0]),
                .b         (b_in[g][7:0]),
                .cin       (cin_in[g]),
                .a_ns      (ans_in[g]),
                .ready     (ready_o[g]),
                .done      (done_o[g]),
                .s         (s8),
                .cout      (cout_o[g]),
                .ovf       (ovf_o[g]),
                .state_dbg (st_o[g])
            );
            assign s_o[g] = {8'h00, s8};
        end else begin : g_w16
            fas_serial #(.WIDTH(16), .DIGIT(1 << (g - 2))) u_dut (
                .clk       (clk),
                .rst       (rst),
                .start     (start[g]),
                .a         (a_in[g]),
                .b         (b_in[g]),
                .cin       (cin_in[g]),
                .a_ns      (ans_in[g]),
                .ready     (ready_o[g]),
                .done      (done_o[g]),
                .s         (s_o[g]),
                .cout      (cout_o[g]),
                .ovf       (ovf_o[g]),
                .state_dbg (st_o[g])
            );
        end
    end

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    // Returns {ovf, cout, s[15:0]} for a w-bit a + (m ? b : ~b) + c.
    function automatic logic [17:0] ref_op(input int w, input logic [15:0] a,
                                           input logic [15:0] b, input logic c,
                                           input logic m);
        longint mask, aa, bb, tot, ss;
        logic co, sa, sb, sr, ov;
        mask = (longint'(1) << w) - 1;
        aa   = longint'(a) & mask;
        bb   = (m ? longint'(b) : ~longint'(b)) & mask;
        tot  = aa + bb + longint'(c);
        ss   = tot & mask;
        co   = ((tot >> w) & 1) != 0;
        sa   = ((aa >> (w - 1)) & 1) != 0;
        sb   = ((bb >> (w - 1)) & 1) != 0;
        sr   = ((ss >> (w - 1)) & 1) != 0;
        ov   = (sa == sb) && (sr != sa);
        return {ov, co, ss[15:0]};
    endfunction

    // ---------------- cycle-level model ----------------
    // m_cnt counts RUN cycles still to go; done follows the edge it reaches 0.
    int          m_cnt  [NI];
    logic        m_done [NI];
    logic [17:0] m_res  [NI];
    logic [17:0] p_res  [NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_cnt[i]  <= 0;
                m_done[i] <= 1'b0;
                m_res[i]  <= '0;
                p_res[i]  <= '0;
            end else if (m_cnt[i] != 0) begin
                m_cnt[i]  <= m_cnt[i] - 1;
                m_done[i] <= (m_cnt[i] == 1);
                if (m_cnt[i] == 1) m_res[i] <= p_res[i];
            end else begin
                m_done[i] <= 1'b0;
                if (start[i]) begin
                    p_res[i] <= ref_op(w_of(i), a_in[i], b_in[i], cin_in[i], ans_in[i]);
                    m_cnt[i] <= w_of(i) / d_of(i);
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                logic [20:0] act, exp;
                act = {st_o[i] == fas_pkg::RUN, ready_o[i], done_o[i],
                       cout_o[i], ovf_o[i], s_o[i]};
                exp = {m_cnt[i] != 0, m_cnt[i] == 0, m_done[i],
                       m_res[i][16], m_res[i][17], m_res[i][15:0]};
                check($sformatf("inst%0d {run,rdy,done,cout,ovf,s}", i), 32'(act), 32'(exp));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic m);
        a_in[i]   = a;
        b_in[i]   = b;
        cin_in[i] = c;
        ans_in[i] = m;
        start[i]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[i]  = 1'b0;
    endtask

    task automatic wait_done(input int i, inout int lat);
        while (done_o[i] !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic m, output int lat);
        issue(i, a, b, c, m);
        lat = 0;
        wait_done(i, lat);
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom_range(0, 65535));
        endcase
    endfunction

    // ---------------- directed vectors ----------------
    logic [7:0] va [5] = '{8'h5A, 8'h10, 8'h80, 8'hFF, 8'hFF};
    logic [7:0] vb [5] = '{8'h3C, 8'h20, 8'h01, 8'h01, 8'hFF};
    logic       vc [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       vm [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] es [5] = '{8'h96, 8'hF0, 8'h7F, 8'h00, 8'hFF};
    logic       ec [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       eo [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    task automatic check_vec(input int i, input int v, input int lat, input string tag);
        check($sformatf("%s lat i%0d v%0d", tag, i, v), 32'(lat), 32'((i == 0) ? 8 : 4));
        check($sformatf("%s s i%0d v%0d", tag, i, v), 32'(s_o[i]), 32'(es[v]));
        check($sformatf("%s cout i%0d v%0d", tag, i, v), 32'(cout_o[i]), 32'(ec[v]));
        check($sformatf("%s ovf i%0d v%0d", tag, i, v), 32'(ovf_o[i]), 32'(eo[v]));
        check($sformatf("%s model i%0d v%0d", tag, i, v), 32'(m_res[i]),
              {14'h0, eo[v], ec[v], 8'h00, es[v]});
    endtask

    initial begin
        int lat;
        int seen;
        logic [15:0] ra, rb;
        logic rc, rm;

        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start[i]  = 1'b0;
            a_in[i]   = '0;
            b_in[i]   = '0;
            cin_in[i] = 1'b0;
            ans_in[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        // reset state
        check("reset ready", 32'(ready_o[0]), 32'd1);
        check("reset done", 32'(done_o[0]), 32'd0);
        check("reset s", 32'(s_o[0]), 32'd0);
        check("reset cout", 32'(cout_o[0]), 32'd0);
        check("reset ovf", 32'(ovf_o[0]), 32'd0);

        // directed vectors on DIGIT=1 and DIGIT=2
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 2; i++) begin
                do_op(i, {8'h00, va[v]}, {8'h00, vb[v]}, vc[v], vm[v], lat);
                check_vec(i, v, lat, "dir");
            end
        end

        // single-cycle done pulse
        @(negedge clk);
        check("done pulse width", 32'(done_o[1]), 32'd0);

        // back-to-back on DIGIT=2: second start lands in the done cycle
        do_op(1, 16'h00FF, 16'h0001, 1'b0, 1'b1, lat);
        check_vec(1, 3, lat, "b2b1");
        check("b2b ready in done cycle", 32'(ready_o[1]), 32'd1);
        do_op(1, 16'h0080, 16'h0001, 1'b1, 1'b0, lat);
        check_vec(1, 2, lat, "b2b2");

        // start and operand changes mid-RUN are ignored
        issue(0, 16'h005A, 16'h003C, 1'b0, 1'b1);
        lat = 0;
        repeat (2) begin
            @(negedge clk);
            lat++;
        end
        a_in[0]   = 16'h0011;
        b_in[0]   = 16'h0022;
        ans_in[0] = 1'b0;
        cin_in[0] = 1'b1;
        start[0]  = 1'b1;
        check("midrun ready", 32'(ready_o[0]), 32'd0);
        @(negedge clk);
        lat++;
        start[0] = 1'b0;
        wait_done(0, lat);
        check_vec(0, 0, lat, "midrun");
        @(negedge clk);

        // reset mid-RUN aborts with no done
        issue(0, 16'h00FF, 16'h0001, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort done", 32'(done_o[0]), 32'd0);
        check("abort s", 32'(s_o[0]), 32'd0);
        check("abort cout", 32'(cout_o[0]), 32'd0);
        check("abort ovf", 32'(ovf_o[0]), 32'd0);
        check("abort ready", 32'(ready_o[0]), 32'd1);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_o[0] === 1'b1) seen++;
        end
        check("abort no late done", 32'(seen), 32'd0);

        // random regression, WIDTH=16, DIGIT 1/2/4/8 in lockstep
        for (int n = 0; n < 1000; n++) begin
            ra = rnd16();
            rb = rnd16();
            rc = 1'($urandom_range(0, 1));
            rm = 1'($urandom_range(0, 1));
            for (int i = 2; i < NI; i++) begin
                a_in[i]   = ra;
                b_in[i]   = rb;
                cin_in[i] = rc;
                ans_in[i] = rm;
                start[i]  = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            for (int i = 2; i < NI; i++) start[i] = 1'b0;
            lat = 0;
            wait_done(2, lat);
            check($sformatf("regr lat n%0d", n), 32'(lat), 32'd16);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
